shift_lane_scheduler: RTL and testbench

// Shares one dual-format alignment barrel shifter between three requesters:
// one FP32 port and two FP16 lanes (high and low).

---
 rtl/shift_lane_scheduler_pkg.sv | 19 +
 rtl/shift_lane_scheduler_barrel_shifter.sv | 58 +++++
 rtl/shift_lane_scheduler.sv | 223 ++++++++++++++++++++++
 tb/tb_shift_lane_scheduler.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_lane_scheduler_pkg.sv
// rtl/shift_lane_scheduler_pkg.sv - shared types and constants for the shift lane scheduler
// Purpose: format enum, scheduler state enum and FP16 lane split point.
// Ports: none (package).
package FPALL_pkg;

  typedef enum logic {
    FP32 = 1'b0,
    FP16 = 1'b1
  } fp_fmt_e;

  typedef enum logic {
    ARB  = 1'b0,
    WAIT = 1'b1
  } sched_state_e;

  // Bit position where the FP16 high-lane result starts inside the 26-bit result.
  localparam int FP16_H_LSB = 13;

endpackage

// File: rtl/shift_lane_scheduler_barrel_shifter.sv
// rtl/shift_lane_scheduler_barrel_shifter.sv - combinational dual-format alignment barrel shifter
// Purpose: FP32 mode shifts one 26-bit field; FP16 mode shifts two independent 13-bit fields.
// Ports: fmt (pass format), x (24-bit packed significand), s (8-bit packed shift),
//        r (26-bit result), sticky_h (FP16 high lane), sticky_l (FP32 or FP16 low lane).
module shift_lane_scheduler_barrel_shifter
  import FPALL_pkg::*;
(
  input  fp_fmt_e     fmt,
  input  logic [23:0] x,
  input  logic [7:0]  s,
  output logic [25:0] r,
  output logic        sticky_h,
  output logic        sticky_l
);

  logic [25:0] v32;
  logic [51:0] w32;
  logic [12:0] vh;
  logic [12:0] vl;
  logic [25:0] wh;
  logic [25:0] wl;

  // Each field carries guard bits below the significand; the wide shift keeps the
  // shifted-out bits in the lower half so sticky is a plain OR of that half.
  always_comb begin
    v32      = {x, 2'b00};
    w32      = {v32, 26'd0} >> s[4:0];
    vh       = {x[23:12], 1'b0};
    vl       = {x[11:0], 1'b0};
    wh       = {vh, 13'd0} >> s[7:4];
    wl       = {vl, 13'd0} >> s[3:0];
    r        = '0;
    sticky_h = 1'b0;
    sticky_l = 1'b0;
    if (fmt == FP32) begin
      if (s[4:0] >= 5'd26) begin
        sticky_l = |v32;
      end else begin
        r        = w32[51:26];
        sticky_l = |w32[25:0];
      end
    end else begin
      if (s[7:4] >= 4'd13) begin
        sticky_h = |vh;
      end else begin
        r[25:13] = wh[25:13];
        sticky_h = |wh[12:0];
      end
      if (s[3:0] >= 4'd13) begin
        sticky_l = |vl;
      end else begin
        r[12:0]  = wl[25:13];
        sticky_l = |wl[12:0];
      end
    end
  end

endmodule

// File: rtl/shift_lane_scheduler.sv
// rtl/shift_lane_scheduler.sv - arbitrates FP32 and paired FP16 requests onto one barrel shifter
// Purpose: round-robin FP32/FP16 classes, pair FP16 lanes (bounded wait), register results.
// Ports: req32_* (FP32 request), req16h_* / req16l_* (FP16 lane requests),
//        res_* (registered result with valid/ready handshake).
module shift_lane_scheduler
  import FPALL_pkg::*;
#(
  parameter int TAG_W     = 4,
  parameter int PAIR_WAIT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req32_valid,
  output logic             req32_ready,
  input  logic [23:0]      req32_x,
  input  logic [4:0]       req32_s,
  input  logic [TAG_W-1:0] req32_tag,
  input  logic             req16h_valid,
  output logic             req16h_ready,
  input  logic [7:0]       req16h_x,
  input  logic [3:0]       req16h_s,
  input  logic [TAG_W-1:0] req16h_tag,
  input  logic             req16l_valid,
  output logic             req16l_ready,
  input  logic [7:0]       req16l_x,
  input  logic [3:0]       req16l_s,
  input  logic [TAG_W-1:0] req16l_tag,
  output logic             res_valid,
  input  logic             res_ready,
  output fp_fmt_e          res_fmt,
  output logic [1:0]       res_lane_mask,
  output logic [25:0]      res_r,
  output logic             res_sticky_h,
  output logic             res_sticky_l,
  output logic [TAG_W-1:0] res_tag32,
  output logic [TAG_W-1:0] res_tag_h,
  output logic [TAG_W-1:0] res_tag_l
);

  localparam int CNT_W = (PAIR_WAIT < 2) ? 1 : $clog2(PAIR_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(PAIR_WAIT);

  sched_state_e     state;
  logic [CNT_W-1:0] wait_cnt;
  logic             rr_fp32_next;
  logic             hold_is_h;
  logic [7:0]       hold_x;
  logic [3:0]       hold_s;
  logic [TAG_W-1:0] hold_tag;

  logic             slot_free;
  logic             p16;
  logic             both_pending;
  logic             grant32;
  logic             grant16;
  logic             partner_valid;
  logic             issue;
  logic             hold_load;
  fp_fmt_e          iss_fmt;
  logic [1:0]       iss_mask;
  logic [7:0]       h_x, l_x;
  logic [3:0]       h_s, l_s;
  logic [TAG_W-1:0] h_tag, l_tag;
  logic [23:0]      sh_x;
  logic [7:0]       sh_s;
  logic [25:0]      sh_r;
  logic             sh_st_h;
  logic             sh_st_l;

  assign slot_free     = !res_valid || res_ready;
  assign p16           = req16h_valid || req16l_valid;
  assign both_pending  = req32_valid && p16;
  assign grant32       = req32_valid && (!p16 || rr_fp32_next);
  assign grant16       = p16 && (!req32_valid || !rr_fp32_next);
  assign partner_valid = hold_is_h ? req16l_valid : req16h_valid;

  always_comb begin
    issue        = 1'b0;
    hold_load    = 1'b0;
    iss_fmt      = FP32;
    iss_mask     = 2'b00;
    req32_ready  = 1'b0;
    req16h_ready = 1'b0;
    req16l_ready = 1'b0;
    case (state)
      ARB: begin
        if (slot_free) begin
          if (grant32) begin
            issue       = 1'b1;
            iss_mask    = 2'b11;
            req32_ready = 1'b1;
          end else if (grant16) begin
            req16h_ready = req16h_valid;
            req16l_ready = req16l_valid;
            if ((req16h_valid && req16l_valid) || PAIR_WAIT == 0) begin
              issue    = 1'b1;
              iss_fmt  = FP16;
              iss_mask = {req16h_valid, req16l_valid};
            end else begin
              hold_load = 1'b1;
            end
          end
        end
      end
      WAIT: begin
        if (slot_free) begin
          if (partner_valid) begin
            issue        = 1'b1;
            iss_fmt      = FP16;
            iss_mask     = 2'b11;
            req16h_ready = !hold_is_h;
            req16l_ready = hold_is_h;
          end else if (wait_cnt == WAIT_MAX) begin
            issue    = 1'b1;
            iss_fmt  = FP16;
            iss_mask = hold_is_h ? 2'b10 : 2'b01;
          end
        end
      end
      default: ;
    endcase
  end

  // Per-lane FP16 operands: the held lane replaces its port while in WAIT;
  // lanes outside the issue mask are zeroed so they contribute nothing.
  always_comb begin
    h_x   = '0;
    h_s   = '0;
    h_tag = '0;
    l_x   = '0;
    l_s   = '0;
    l_tag = '0;
    if (iss_fmt == FP16) begin
      if (iss_mask[1]) begin
        if (state == WAIT && hold_is_h) begin
          h_x = hold_x; h_s = hold_s; h_tag = hold_tag;
        end else begin
          h_x = req16h_x; h_s = req16h_s; h_tag = req16h_tag;
        end
      end
      if (iss_mask[0]) begin
        if (state == WAIT && !hold_is_h) begin
          l_x = hold_x; l_s = hold_s; l_tag = hold_tag;
        end else begin
          l_x = req16l_x; l_s = req16l_s; l_tag = req16l_tag;
        end
      end
    end
  end

  assign sh_x = (iss_fmt == FP32) ? req32_x : {h_x, 4'b0000, l_x, 4'b0000};
  assign sh_s = (iss_fmt == FP32) ? {3'b000, req32_s} : {h_s, l_s};

  shift_lane_scheduler_barrel_shifter u_shifter (
    .fmt      (iss_fmt),
    .x        (sh_x),
    .s        (sh_s),
    .r        (sh_r),
    .sticky_h (sh_st_h),
    .sticky_l (sh_st_l)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ARB;
      wait_cnt      <= '0;
      rr_fp32_next  <= 1'b1;
      hold_is_h     <= 1'b0;
      hold_x        <= '0;
      hold_s        <= '0;
      hold_tag      <= '0;
      res_valid     <= 1'b0;
      res_fmt       <= FP32;
      res_lane_mask <= 2'b00;
      res_r         <= '0;
      res_sticky_h  <= 1'b0;
      res_sticky_l  <= 1'b0;
      res_tag32     <= '0;
      res_tag_h     <= '0;
      res_tag_l     <= '0;
    end else begin
      if (state == ARB && slot_free && both_pending) begin
        rr_fp32_next <= !rr_fp32_next;
      end
      case (state)
        ARB: begin
          if (hold_load) begin
            state     <= WAIT;
            wait_cnt  <= CNT_W'(1);
            hold_is_h <= req16h_valid;
            hold_x    <= req16h_valid ? req16h_x : req16l_x;
            hold_s    <= req16h_valid ? req16h_s : req16l_s;
            hold_tag  <= req16h_valid ? req16h_tag : req16l_tag;
          end
        end
        WAIT: begin
          if (issue) begin
            state    <= ARB;
            wait_cnt <= '0;
          end else if (wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= ARB;
      endcase
      if (issue) begin
        res_valid     <= 1'b1;
        res_fmt       <= iss_fmt;
        res_lane_mask <= iss_mask;
        res_r         <= {iss_mask[1] ? sh_r[25:FP16_H_LSB] : 13'd0,
                          iss_mask[0] ? sh_r[FP16_H_LSB-1:0] : 13'd0};
        res_sticky_h  <= (iss_fmt == FP16) && iss_mask[1] && sh_st_h;
        res_sticky_l  <= iss_mask[0] && sh_st_l;
        res_tag32     <= (iss_fmt == FP32) ? req32_tag : '0;
        res_tag_h     <= h_tag;
        res_tag_l     <= l_tag;
      end else if (res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_shift_lane_scheduler.sv
// tb/tb_shift_lane_scheduler.sv - directed self-checking bench for shift_lane_scheduler
module tb_shift_lane_scheduler;
  import FPALL_pkg::*;

  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req32_valid;
  logic             req32_ready;
  logic [23:0]      req32_x;
  logic [4:0]       req32_s;
  logic [TAG_W-1:0] req32_tag;
  logic             req16h_valid;
  logic             req16h_ready;
  logic [7:0]       req16h_x;
  logic [3:0]       req16h_s;
  logic [TAG_W-1:0] req16h_tag;
  logic             req16l_valid;
  logic             req16l_ready;
  logic [7:0]       req16l_x;
  logic [3:0]       req16l_s;
  logic [TAG_W-1:0] req16l_tag;
  logic             res_valid;
  logic             res_ready;
  fp_fmt_e          res_fmt;
  logic [1:0]       res_lane_mask;
  logic [25:0]      res_r;
  logic             res_sticky_h;
  logic             res_sticky_l;
  logic [TAG_W-1:0] res_tag32;
  logic [TAG_W-1:0] res_tag_h;
  logic [TAG_W-1:0] res_tag_l;

  int total = 0;
  int bad   = 0;

  shift_lane_scheduler #(.TAG_W(TAG_W), .PAIR_WAIT(3)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req32_valid   (req32_valid),
    .req32_ready   (req32_ready),
    .req32_x       (req32_x),
    .req32_s       (req32_s),
    .req32_tag     (req32_tag),
    .req16h_valid  (req16h_valid),
    .req16h_ready  (req16h_ready),
    .req16h_x      (req16h_x),
    .req16h_s      (req16h_s),
    .req16h_tag    (req16h_tag),
    .req16l_valid  (req16l_valid),
    .req16l_ready  (req16l_ready),
    .req16l_x      (req16l_x),
    .req16l_s      (req16l_s),
    .req16l_tag    (req16l_tag),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_fmt       (res_fmt),
    .res_lane_mask (res_lane_mask),
    .res_r         (res_r),
    .res_sticky_h  (res_sticky_h),
    .res_sticky_l  (res_sticky_l),
    .res_tag32     (res_tag32),
    .res_tag_h     (res_tag_h),
    .res_tag_l     (res_tag_l)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req32_valid  = 1'b0;
    req16h_valid = 1'b0;
    req16l_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; res_ready = 1'b1;
    idle();
    req32_x = '0; req32_s = '0; req32_tag = '0;
    req16h_x = '0; req16h_s = '0; req16h_tag = '0;
    req16l_x = '0; req16l_s = '0; req16l_tag = '0;
    tick(); tick();
    chk("rst_valid", res_valid, 0);
    chk("rst_r", res_r, 0);
    chk("rst_mask", res_lane_mask, 0);
    chk("rst_fmt", res_fmt, FP32);
    chk("rst_tag32", res_tag32, 0);
    chk("rst_sticky_l", res_sticky_l, 0);
    rst_n = 1'b1;

    // FP32 single requests
    req32_valid = 1'b1; req32_x = 24'h000003; req32_s = 5'd1; req32_tag = 4'd5;
    #1 chk("fp32_ready", req32_ready, 1);
    tick();
    chk("fp32_s1_valid", res_valid, 1);
    chk("fp32_s1_r", res_r, 26'h0000006);
    chk("fp32_s1_sticky", res_sticky_l, 0);
    chk("fp32_s1_mask", res_lane_mask, 2'b11);
    chk("fp32_s1_fmt", res_fmt, FP32);
    chk("fp32_s1_tag", res_tag32, 5);
    chk("fp32_s1_tagh", res_tag_h, 0);
    req32_s = 5'd3; req32_tag = 4'd6;
    tick();
    chk("fp32_s3_r", res_r, 26'h0000001);
    chk("fp32_s3_sticky", res_sticky_l, 1);
    chk("fp32_s3_tag", res_tag32, 6);
    req32_x = 24'hFFFFFF; req32_s = 5'd26;
    tick();
    chk("fp32_s26_r", res_r, 0);
    chk("fp32_s26_sticky", res_sticky_l, 1);
    req32_x = 24'h800000; req32_s = 5'd25;
    tick();
    chk("fp32_s25_r", res_r, 26'h0000001);
    chk("fp32_s25_sticky", res_sticky_l, 0);
    idle();
    tick();
    chk("fp32_drain", res_valid, 0);

    // FP16 pair in one cycle
    req16h_valid = 1'b1; req16h_x = 8'h80; req16h_s = 4'd1; req16h_tag = 4'd1;
    req16l_valid = 1'b1; req16l_x = 8'hC0; req16l_s = 4'd2; req16l_tag = 4'd2;
    #1;
    chk("pair_h_ready", req16h_ready, 1);
    chk("pair_l_ready", req16l_ready, 1);
    chk("pair_32_ready", req32_ready, 0);
    tick();
    chk("pair_fmt", res_fmt, FP16);
    chk("pair_r", res_r, {13'h0800, 13'h0600});
    chk("pair_st_h", res_sticky_h, 0);
    chk("pair_st_l", res_sticky_l, 0);
    chk("pair_mask", res_lane_mask, 2'b11);
    chk("pair_tag_h", res_tag_h, 1);
    chk("pair_tag_l", res_tag_l, 2);
    chk("pair_tag32", res_tag32, 0);
    req16h_x = 8'h01; req16h_s = 4'd6; req16l_x = 8'hFF; req16l_s = 4'd15;
    tick();
    chk("pair_st_r", res_r, 0);
    chk("pair_st_h1", res_sticky_h, 1);
    chk("pair_st_l1", res_sticky_l, 1);
    idle();
    tick();
    chk("pair_drain", res_valid, 0);

    // Lone low lane, no partner: solo issue when wait_cnt reaches 3
    req16l_valid = 1'b1; req16l_x = 8'h40; req16l_s = 4'd0; req16l_tag = 4'd7;
    #1;
    chk("lone_l_ready", req16l_ready, 1);
    chk("lone_h_ready", req16h_ready, 0);
    tick();
    idle();
    chk("lone_c0_valid", res_valid, 0);
    req32_valid = 1'b1; req16l_valid = 1'b1;
    #1;
    chk("wait_32_ready", req32_ready, 0);
    chk("wait_held_ready", req16l_ready, 0);
    idle();
    tick();
    chk("lone_c1_valid", res_valid, 0);
    tick();
    chk("lone_c2_valid", res_valid, 0);
    tick();
    chk("lone_c3_valid", res_valid, 1);
    chk("lone_mask", res_lane_mask, 2'b01);
    chk("lone_fmt", res_fmt, FP16);
    chk("lone_r", res_r, {13'h0000, 13'h0800});
    chk("lone_tag_l", res_tag_l, 7);
    chk("lone_tag_h", res_tag_h, 0);
    tick();
    chk("lone_drain", res_valid, 0);

    // Lone low lane, partner high lane arrives at cycle 2
    req16l_valid = 1'b1; req16l_x = 8'h11; req16l_s = 4'd1; req16l_tag = 4'd3;
    tick();
    idle();
    tick();
    req16h_valid = 1'b1; req16h_x = 8'h22; req16h_s = 4'd0; req16h_tag = 4'd4;
    #1 chk("partner_h_ready", req16h_ready, 1);
    tick();
    idle();
    chk("partner_valid", res_valid, 1);
    chk("partner_mask", res_lane_mask, 2'b11);
    chk("partner_r", res_r, {13'h0440, 13'h0110});
    chk("partner_tag_h", res_tag_h, 4);
    chk("partner_tag_l", res_tag_l, 3);
    tick();
    chk("partner_drain", res_valid, 0);

    // All three requesters valid continuously: FP32 first, then alternate
    req32_valid = 1'b1; req32_x = 24'h000001; req32_s = 5'd0; req32_tag = 4'd9;
    req16h_valid = 1'b1; req16h_x = 8'hF0; req16h_s = 4'd4; req16h_tag = 4'd10;
    req16l_valid = 1'b1; req16l_x = 8'h0F; req16l_s = 4'd0; req16l_tag = 4'd11;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_32_ready", req32_ready, (i % 2) == 0);
      chk("rr_h_ready", req16h_ready, (i % 2) == 1);
      tick();
      chk("rr_valid", res_valid, 1);
      chk("rr_fmt", res_fmt, ((i % 2) == 0) ? FP32 : FP16);
      chk("rr_r", res_r, ((i % 2) == 0) ? 26'h0000004 : {13'h01E0, 13'h01E0});
    end

    // Back-pressure: nothing accepted, result held, no bubble on release
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("stall_32_ready", req32_ready, 0);
      chk("stall_h_ready", req16h_ready, 0);
      chk("stall_l_ready", req16l_ready, 0);
      tick();
      chk("stall_valid", res_valid, 1);
      chk("stall_fmt", res_fmt, FP16);
      chk("stall_r", res_r, {13'h01E0, 13'h01E0});
    end
    res_ready = 1'b1;
    #1 chk("release_32_ready", req32_ready, 1);
    tick();
    chk("release_fmt", res_fmt, FP32);
    chk("release_tag32", res_tag32, 9);
    tick();
    chk("release_next_valid", res_valid, 1);
    chk("release_next_fmt", res_fmt, FP16);
    idle();
    tick();
    chk("release_drain", res_valid, 0);

    // Reset while a lone lane is held
    req16l_valid = 1'b1; req16l_x = 8'h01; req16l_s = 4'd0; req16l_tag = 4'd2;
    #1 chk("rstwait_l_ready", req16l_ready, 1);
    tick();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rstwait_valid", res_valid, 0);
    req32_valid = 1'b1; req32_x = 24'h000002; req32_s = 5'd0; req32_tag = 4'd3;
    #1 chk("rstwait_arb_ready", req32_ready, 1);
    tick();
    idle();
    chk("rstwait_fmt", res_fmt, FP32);
    chk("rstwait_r", res_r, 26'h0000008);
    chk("rstwait_tag32", res_tag32, 3);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rstwait_no_held", res_valid, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
